// File: rtl/bdu_bit_streamer_if.sv
// rtl/bdu_bit_streamer_if.sv - query/reference handshake, BDU beat and status bundle for bdu_bit_streamer
// master = host/BDU side driving the streamer, slave = the streamer itself.
interface bdu_bit_streamer_if #(
   parameter int BIT_WIDTH = 32,
   parameter int BW        = $clog2(BIT_WIDTH + 1)
);
   logic                 q_load;
   logic [BIT_WIDTH-1:0] q_x;
   logic [BIT_WIDTH-1:0] q_y;
   logic [BIT_WIDTH-1:0] q_z;

   logic                 ref_valid;
   logic                 ref_ready;
   logic [BIT_WIDTH-1:0] ref_x;
   logic [BIT_WIDTH-1:0] ref_y;
   logic [BIT_WIDTH-1:0] ref_z;

   logic                 complete;
   logic                 valid;
   logic                 q_bit;
   logic                 r_bit;
   logic [1:0]           code;
   logic [BW-1:0]        b;
   logic                 shift;

   logic                 point_done;
   logic                 point_term;
   logic                 busy;
   logic [15:0]          cnt_done;
   logic [15:0]          cnt_term;

   modport master (
      output q_load, q_x, q_y, q_z,
      output ref_valid, ref_x, ref_y, ref_z,
      output complete,
      input  ref_ready, valid, q_bit, r_bit, code, b, shift,
      input  point_done, point_term, busy, cnt_done, cnt_term
   );

   modport slave (
      input  q_load, q_x, q_y, q_z,
      input  ref_valid, ref_x, ref_y, ref_z,
      input  complete,
      output ref_ready, valid, q_bit, r_bit, code, b, shift,
      output point_done, point_term, busy, cnt_done, cnt_term
   );
endinterface

// File: rtl/bdu_bit_streamer.sv
// rtl/bdu_bit_streamer.sv - serializes query/reference points MSB-first, x/y/z interleaved, into one BDU
// Define BDU_STREAM_EARLY_TERM_EN to abandon a point as soon as the BDU raises complete mid-stream.
module bdu_bit_streamer #(
   parameter int BIT_WIDTH = 32
) (
   input logic               clk,
   input logic               rst,
   bdu_bit_streamer_if.slave bus
);
   localparam int BW = $clog2(BIT_WIDTH + 1);
   localparam logic [BW-1:0] B_LAST = BW'(BIT_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DRAIN,
      S_SHIFT
   } state_t;

   state_t state;
   state_t state_nxt;

   logic                 q_loaded;
   logic [BIT_WIDTH-1:0] qx_r, qy_r, qz_r;
   logic [BIT_WIDTH-1:0] rx_r, ry_r, rz_r;

   logic [BW-1:0]        b_r, b_nxt;
   logic [1:0]           code_r, code_nxt;
   logic                 q_bit_r, q_bit_nxt;
   logic                 r_bit_r, r_bit_nxt;
   logic [15:0]          cnt_done_r;

   logic                 q_take;
   logic                 hs;
   logic                 last_beat;
   logic                 early;

   logic [BIT_WIDTH-1:0] r_src_x, r_src_y, r_src_z;
   logic [BIT_WIDTH-1:0] q_sel, r_sel, q_sh, r_sh;

   assign q_take        = (state == S_IDLE) && bus.q_load;
   assign bus.ref_ready = (state == S_IDLE) && q_loaded && !bus.q_load;
   assign hs            = bus.ref_valid && bus.ref_ready;
   // code doubles as the mod-3 phase counter, b as the bit-ordinal counter
   assign last_beat     = (b_r == B_LAST) && (code_r == 2'd3);

`ifdef BDU_STREAM_EARLY_TERM_EN
   assign early     = (state == S_STREAM) && bus.complete;
   assign bus.valid = (state == S_STREAM) && !bus.complete;
`else
   assign early     = 1'b0;
   assign bus.valid = (state == S_STREAM);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      b_nxt     = '0;
      code_nxt  = 2'd0;
      unique case (state)
         S_IDLE: begin
            if (hs) begin
               state_nxt = S_STREAM;
               b_nxt     = BW'(1);
               code_nxt  = 2'd1;
            end
         end
         S_STREAM: begin
            if (early) begin
               state_nxt = S_SHIFT;
            end else if (last_beat) begin
               state_nxt = S_DRAIN;
            end else if (code_r == 2'd3) begin
               b_nxt    = b_r + 1'b1;
               code_nxt = 2'd1;
            end else begin
               b_nxt    = b_r;
               code_nxt = code_r + 2'd1;
            end
         end
         S_DRAIN: begin
            if (bus.complete) begin
               state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // On the handshake cycle the reference is not latched yet, so take it straight off the bus.
   always_comb begin
      r_src_x = (state == S_IDLE) ? bus.ref_x : rx_r;
      r_src_y = (state == S_IDLE) ? bus.ref_y : ry_r;
      r_src_z = (state == S_IDLE) ? bus.ref_z : rz_r;
      q_sel   = '0;
      r_sel   = '0;
      case (code_nxt)
         2'd1: begin
            q_sel = qx_r;
            r_sel = r_src_x;
         end
         2'd2: begin
            q_sel = qy_r;
            r_sel = r_src_y;
         end
         2'd3: begin
            q_sel = qz_r;
            r_sel = r_src_z;
         end
         default: begin
            q_sel = '0;
            r_sel = '0;
         end
      endcase
      q_sh      = q_sel >> (B_LAST - b_nxt);
      r_sh      = r_sel >> (B_LAST - b_nxt);
      q_bit_nxt = q_sh[0];
      r_bit_nxt = r_sh[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_loaded   <= 1'b0;
         b_r        <= '0;
         code_r     <= 2'd0;
         q_bit_r    <= 1'b0;
         r_bit_r    <= 1'b0;
         cnt_done_r <= 16'd0;
      end else begin
         b_r     <= b_nxt;
         code_r  <= code_nxt;
         q_bit_r <= q_bit_nxt;
         r_bit_r <= r_bit_nxt;
         if (q_take) begin
            q_loaded <= 1'b1;
         end
         // counted on entry so the SHIFT cycle already shows the new total
         if (state_nxt == S_SHIFT) begin
            cnt_done_r <= cnt_done_r + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (q_take) begin
         qx_r <= bus.q_x;
         qy_r <= bus.q_y;
         qz_r <= bus.q_z;
      end
      if (hs) begin
         rx_r <= bus.ref_x;
         ry_r <= bus.ref_y;
         rz_r <= bus.ref_z;
      end
   end

`ifdef BDU_STREAM_EARLY_TERM_EN
   logic        term_r;
   logic [15:0] cnt_term_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         term_r     <= 1'b0;
         cnt_term_r <= 16'd0;
      end else if (early) begin
         term_r     <= 1'b1;
         cnt_term_r <= cnt_term_r + 16'd1;
      end else if (hs) begin
         term_r <= 1'b0;
      end
   end

   assign bus.point_term = (state == S_SHIFT) && term_r;
   assign bus.cnt_term   = cnt_term_r;
`else
   assign bus.point_term = 1'b0;
   assign bus.cnt_term   = 16'd0;
`endif

   assign bus.q_bit      = q_bit_r;
   assign bus.r_bit      = r_bit_r;
   assign bus.code       = code_r;
   assign bus.b          = b_r;
   assign bus.shift      = (state == S_SHIFT);
   assign bus.point_done = (state == S_SHIFT);
   assign bus.busy       = (state != S_IDLE);
   assign bus.cnt_done   = cnt_done_r;
endmodule

// File: tb/tb_bdu_bit_streamer.sv
// tb/tb_bdu_bit_streamer.sv - randomized scoreboard bench for bdu_bit_streamer
// Expected beats/results come from an arithmetic model of the bit ordering, popped by a negedge monitor.
module tb_bdu_bit_streamer;
   localparam int W  = 4;
   localparam int BW = $clog2(W + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bdu_bit_streamer_if #(.BIT_WIDTH(W)) ifc ();
   bdu_bit_streamer #(.BIT_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(ifc));

   int total = 0;
   int bad   = 0;

   logic [6:0]  beat_q[$];
   logic [32:0] done_q[$];

   logic [W-1:0] mqx, mqy, mqz;
   int npts  = 0;
   int nterm = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] all_outs();
      return {19'd0, ifc.ref_ready, ifc.valid, ifc.q_bit, ifc.r_bit, ifc.code, ifc.b,
              ifc.shift, ifc.point_done, ifc.point_term, ifc.busy, ifc.cnt_done, ifc.cnt_term};
   endfunction

   // beat k carries bit ordinal k/3+1 (MSB first) of dimension k%3
   function automatic logic [6:0] exp_beat(input int k, input logic [W-1:0] rx, ry, rz);
      int bb;
      int cc;
      logic [W-1:0] qc, rc;
      bb = k / 3 + 1;
      cc = k % 3 + 1;
      qc = (cc == 1) ? mqx : (cc == 2) ? mqy : mqz;
      rc = (cc == 1) ? rx : (cc == 2) ? ry : rz;
      qc = qc >> (W - bb);
      rc = rc >> (W - bb);
      return {2'(cc), 3'(bb), qc[0], rc[0]};
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         chk("valid_outside_stream", {63'd0, ifc.valid && (!ifc.busy || ifc.shift)}, 64'd0);
         if (ifc.valid) begin
            if (beat_q.size() == 0) begin
               chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
               chk("beat", {57'd0, ifc.code, ifc.b, ifc.q_bit, ifc.r_bit}, {57'd0, beat_q.pop_front()});
            end
         end
         if (ifc.point_done) begin
            if (done_q.size() == 0) begin
               chk("unexpected_done", 64'd1, 64'd0);
            end else begin
               chk("done", {31'd0, ifc.point_term, ifc.cnt_done, ifc.cnt_term}, {31'd0, done_q.pop_front()});
            end
         end
      end
   end

   task automatic load_query(input logic [W-1:0] x, y, z);
      ifc.q_load = 1'b1;
      ifc.q_x = x;
      ifc.q_y = y;
      ifc.q_z = z;
      step();
      ifc.q_load = 1'b0;
      mqx = x;
      mqy = y;
      mqz = z;
   endtask

   // returns in the cycle carrying beat 0
   task automatic offer(input logic [W-1:0] rx, ry, rz, input int nbeats, input bit term);
      ifc.ref_x = rx;
      ifc.ref_y = ry;
      ifc.ref_z = rz;
      ifc.ref_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (ifc.ref_ready) begin
            for (int k = 0; k < nbeats; k++) beat_q.push_back(exp_beat(k, rx, ry, rz));
            npts++;
            if (term) nterm++;
            done_q.push_back({term, 16'(npts), 16'(nterm)});
            step();
            ifc.ref_valid = 1'b0;
            return;
         end
         step();
      end
      ifc.ref_valid = 1'b0;
      chk("ref_ready_timeout", 64'd0, 64'd1);
   endtask

   task automatic finish_point(input int term_at, input int drain_delay, input int glitch_k, input bit midq);
      for (int k = 0; k < 3 * W; k++) begin
`ifdef BDU_STREAM_EARLY_TERM_EN
         if (k == term_at) begin
            ifc.complete = 1'b1;
            ifc.q_load = 1'b0;
            #1;
            chk("term_beat_suppressed", {63'd0, ifc.valid}, 64'd0);
            step();
            ifc.complete = 1'b0;
            chk("term_shift", {61'd0, ifc.shift, ifc.point_done, ifc.point_term}, 64'd7);
            step();
            chk("term_idle", {63'd0, ifc.busy}, 64'd0);
            return;
         end
`endif
         ifc.complete = (k == glitch_k);
         if (midq && k == 2) begin
            ifc.q_load = 1'b1;
            ifc.q_x = ~mqx;
            ifc.q_y = ~mqy;
            ifc.q_z = ~mqz;
         end else begin
            ifc.q_load = 1'b0;
         end
         step();
      end
      ifc.complete = 1'b0;
      ifc.q_load = 1'b0;
      for (int d = 0; d < drain_delay + 1; d++) begin
         chk("drain_state", {56'd0, ifc.busy, ifc.valid, ifc.shift, ifc.code, ifc.b}, {56'd0, 1'b1, 7'd0});
         if (d == drain_delay) ifc.complete = 1'b1;
         step();
      end
      ifc.complete = 1'b0;
      chk("shift_pulse", {61'd0, ifc.shift, ifc.point_done, ifc.point_term}, 64'd6);
      step();
      chk("idle_after_shift", {63'd0, ifc.busy}, 64'd0);
   endtask

   task automatic summary();
      $display("test done: total=%0d bad=%0d", total, bad);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      bad++;
      summary();
      $finish;
   end

   initial begin
      int term_at;
      int glitch;
      logic [W-1:0] rx, ry, rz;

      ifc.q_load = 1'b0;
      ifc.q_x = '0;
      ifc.q_y = '0;
      ifc.q_z = '0;
      ifc.ref_valid = 1'b0;
      ifc.ref_x = '0;
      ifc.ref_y = '0;
      ifc.ref_z = '0;
      ifc.complete = 1'b0;

      repeat (3) step();
      chk("reset_outputs", all_outs(), 64'd0);
      rst = 1'b0;

      // no query loaded: reference must never be accepted
      ifc.ref_valid = 1'b1;
      ifc.ref_x = 4'd3;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("no_query_ready", {62'd0, ifc.ref_ready, ifc.valid}, 64'd0);
         step();
      end
      ifc.ref_valid = 1'b0;

      // directed point: query (5,0,0), reference (3,0,0)
      load_query(4'd5, 4'd0, 4'd0);
      offer(4'd3, 4'd0, 4'd0, 3 * W, 1'b0);
      finish_point(-1, 0, -1, 1'b0);

      // q_load wins over a same-cycle reference, then the new query is used
      ifc.ref_x = 4'd6;
      ifc.ref_y = 4'd10;
      ifc.ref_z = 4'd12;
      ifc.ref_valid = 1'b1;
      ifc.q_load = 1'b1;
      ifc.q_x = 4'd9;
      ifc.q_y = 4'd2;
      ifc.q_z = 4'd7;
      #1;
      chk("qload_priority", {63'd0, ifc.ref_ready}, 64'd0);
      step();
      ifc.q_load = 1'b0;
      mqx = 4'd9;
      mqy = 4'd2;
      mqz = 4'd7;
      #1;
      chk("ready_after_qload", {63'd0, ifc.ref_ready}, 64'd1);
      offer(4'd6, 4'd10, 4'd12, 3 * W, 1'b0);
      finish_point(-1, 1, -1, 1'b1);
      offer(4'd15, 4'd1, 4'd8, 3 * W, 1'b0);
      finish_point(-1, 0, -1, 1'b0);

`ifdef BDU_STREAM_EARLY_TERM_EN
      offer(4'd11, 4'd4, 4'd13, 7, 1'b1);
      finish_point(7, 0, -1, 1'b0);
      offer(4'd2, 4'd9, 4'd5, 3 * W - 1, 1'b1);
      finish_point(3 * W - 1, 0, -1, 1'b0);
`else
      offer(4'd11, 4'd4, 4'd13, 3 * W, 1'b0);
      finish_point(-1, 0, 3 * W - 1, 1'b0);
`endif

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 7) == 0) load_query(W'($urandom), W'($urandom), W'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            ifc.complete = 1'b1;
            step();
            ifc.complete = 1'b0;
            chk("idle_complete_ignored", {63'd0, ifc.busy}, 64'd0);
         end
         rx = W'($urandom);
         ry = W'($urandom);
         rz = W'($urandom);
         term_at = -1;
         glitch = -1;
`ifdef BDU_STREAM_EARLY_TERM_EN
         if ($urandom_range(0, 2) == 0) term_at = int'($urandom_range(0, 3 * W - 1));
`else
         if ($urandom_range(0, 2) == 0) glitch = int'($urandom_range(0, 3 * W - 1));
`endif
         offer(rx, ry, rz, (term_at >= 0) ? term_at : 3 * W, term_at >= 0);
         finish_point(term_at, int'($urandom_range(0, 2)), glitch, (n % 10) == 3);
      end

      // reset mid-stream
      offer(4'd7, 4'd14, 4'd1, 3 * W, 1'b0);
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      beat_q.delete();
      done_q.delete();
      npts = 0;
      nterm = 0;
      ifc.ref_valid = 1'b1;
      #1;
      chk("midstream_reset_outputs", all_outs(), 64'd0);
      ifc.ref_valid = 1'b0;
      step();
      load_query(4'd12, 4'd3, 4'd10);
      offer(4'd5, 4'd6, 4'd9, 3 * W, 1'b0);
      finish_point(-1, 0, -1, 1'b0);

      step();
      chk("beats_drained", 64'(beat_q.size()), 64'd0);
      chk("dones_drained", 64'(done_q.size()), 64'd0);
      summary();
      $finish;
   end
endmodule

// File: doc/bdu_bit_streamer.md
# bdu_bit_streamer

Bit-serial front end that drives one BDU. It holds a query point, accepts reference points over a valid/ready handshake, and serializes both MSB-first with x/y/z interleaved onto the BDU's `valid`/`q_bit`/`r_bit`/`code`/`b` inputs. It watches the BDU's `complete`, pulses `shift` to clear the BDU between points, and reports per-point status to the KNN sorter that consumes `bdu_out`.

## Interface
Parameters:
- `BIT_WIDTH`, default 32: coordinate width per dimension; matches the BDU.

Ports (`BW = $clog2(BIT_WIDTH+1)`):
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `q_load` input 1: load a new query point; honoured only in IDLE.
- `q_x`, `q_y`, `q_z` input BIT_WIDTH each: query coordinates, sampled when `q_load` is honoured.
- `ref_valid` input 1: reference point offered.
- `ref_ready` output 1: streamer accepts the reference point this cycle.
- `ref_x`, `ref_y`, `ref_z` input BIT_WIDTH each: reference coordinates.
- `complete` input 1: BDU `complete`.
- `valid` output 1: beat valid to BDU.
- `q_bit`, `r_bit` output 1 each: current query and reference bits.
- `code` output 2: dimension select; 01 = x, 10 = y, 11 = z, 00 when idle.
- `b` output BW: bit ordinal, 1 = MSB ... BIT_WIDTH = LSB; 0 when idle.
- `shift` output 1: one-cycle clear pulse to the BDU.
- `point_done` output 1: one-cycle pulse; the BDU result is final this cycle.
- `point_term` output 1: qualifies `point_done`; 1 = point terminated early.
- `busy` output 1: state is not IDLE.
- `cnt_done` output 16: points finished since reset; wraps.
- `cnt_term` output 16: points terminated early since reset; wraps.

## Operation
- State machine: IDLE → STREAM → DRAIN → SHIFT → IDLE. STREAM can also go directly to SHIFT on early termination.
- `q_loaded` flag is cleared by reset and set by an honoured `q_load`.
- `ref_ready = (state==IDLE) && q_loaded && !q_load`.
  - `q_load` has priority over a reference offered in the same cycle.
  - `q_load` outside IDLE is ignored and leaves the query unchanged.
- Handshake `ref_valid && ref_ready`: latch `ref_*`, clear the beat counter `k` (range 0..3·BIT_WIDTH−1), go to STREAM.
- STREAM, beat `k`:
  - `b = k/3 + 1`; `code = (k%3) + 1`.
  - `q_bit` = bit [BIT_WIDTH−b] of the selected query coordinate; `r_bit` = the same bit of the selected reference coordinate.
  - `valid = 1`, except as in Configuration.
  - Implement `k/3` as a `b` counter plus a mod-3 phase counter; no divider.
- After beat `k = 3·BIT_WIDTH−1`: go to DRAIN.
  - `valid = 0`, `code = 0`, `b = 0`.
  - Wait for `complete`, with no timeout; the BDU asserts it the cycle after the last beat.
- SHIFT lasts one cycle:
  - `shift = 1`, `point_done = 1`.
  - `point_term = 1` only if SHIFT was entered from STREAM.
  - `cnt_done` +1; `cnt_term` +1 when `point_term`.
  - Next state IDLE.
- `shift` is asserted only in SHIFT.
- `valid` is never high in IDLE, DRAIN or SHIFT.
- Reset (any state, including mid-stream):
  - State IDLE, `q_loaded = 0`, counters 0.
  - Every output 0, including `ref_ready`, because `q_loaded = 0`.

## Timing
- Handshake in cycle T → first beat (`k = 0`, `b = 1`, `code = 01`) in cycle T+1.
- Full-length point: beats T+1 .. T+3·BIT_WIDTH, DRAIN from T+3·BIT_WIDTH+1, SHIFT at T+3·BIT_WIDTH+2, `ref_ready` again at T+3·BIT_WIDTH+3.
  - Throughput: one point per 3·BIT_WIDTH+3 cycles.
- Early termination seen in STREAM cycle C: beat suppressed in C, SHIFT at C+1, IDLE at C+2.
- `complete` in IDLE or SHIFT is ignored.
- `complete` and the last beat in the same cycle: with EARLY_TERM_EN this is treated as early termination; without it the streamer goes to DRAIN.
- `q_bit`, `r_bit`, `code`, `b` are registered. `valid` may combinationally include `complete`.

## Configuration
- `BDU_STREAM_EARLY_TERM_EN` defined:
  - In STREAM, `valid = !complete`.
  - `complete` high moves STREAM → SHIFT and abandons the remaining beats.
- Not defined:
  - `complete` is ignored in STREAM; every point streams all 3·BIT_WIDTH beats.
  - `point_term` and `cnt_term` are tied to 0.

## Test plan
- BIT_WIDTH=4, query (5,0,0), ref (3,0,0): beats 0..2 show `code` 01/10/11, `b` = 1.
  - x beats for b = 1..4 give `q_bit` 0,1,0,1 and `r_bit` 0,0,1,1.
  - Stub `complete` at T+13 → SHIFT at T+14, `point_done = 1`, `point_term = 0`, `cnt_done = 1`.
- No `q_load` since reset, `ref_valid` held high → `ref_ready` stays 0 for 20 cycles and `valid` never rises.
- EARLY_TERM_EN, BIT_WIDTH=32, `complete` forced at beat 7 → `valid = 0` that cycle, `shift` the next cycle, `point_term = 1`, `cnt_term = 1`.
- `q_load` (q_x = 9) in the same cycle as `ref_valid` in IDLE → `ref_ready = 0`.
  - The next cycle the reference is accepted and streams using q_x = 9.
  - A later `q_load` mid-stream leaves the query unchanged.
- `rst` pulse at beat 50 → the next cycle all outputs are 0 and state is IDLE; after `q_load`, a new point streams from `b = 1`.
- 65 536 full-length points → `cnt_done` wraps to 0.
